v810_bus_arb: RTL

Arbiter between the instruction-fetch unit and the execution-unit data port. It drives the single EU-side request interface (EDA/EDREQ/EDACK...) of v810_mem.
- Locks the grant to one requester for the whole transaction.
- Gives data accesses priority, with a starvation guard for fetches.
- Supports fetch flush on branch: an in-flight fetch completes on the bus, but its result is discarded.

---
 rtl/v810_bus_pkg.sv | 11 +
 rtl/v810_bus_arb.sv | 70 +++++++
 2 files changed

// File: rtl/v810_bus_pkg.sv
// v810_bus_pkg: ownership encoding and request payload shared by the bus arbiter and fetch unit
package v810_bus_pkg;
  typedef enum logic [1:0] {ARB_IDLE = 2'd0, ARB_IF = 2'd1, ARB_EU = 2'd2} arb_own_t;
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [1:0]  bc;
    logic [3:0]  be;
    logic        wr;
  } bus_req_t;
endpackage

// File: rtl/v810_bus_arb.sv
// v810_bus_arb: locks the v810_mem request port to fetch or data unit, data first with fetch starvation guard
module v810_bus_arb
  import v810_bus_pkg::*;
#(
  parameter int STARVE_MAX = 3,
  parameter int CNT_W = 4
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic        CE,
  input  logic [29:0] IFA,
  input  logic        IFREQ,
  output logic [31:0] IFD,
  output logic        IFACK,
  input  logic        IFFLUSH,
  input  logic [31:0] EUA,
  input  logic [31:0] EUD_O,
  output logic [31:0] EUD_I,
  input  logic [1:0]  EUBC,
  input  logic [3:0]  EUBE,
  input  logic        EUWR,
  input  logic        EUREQ,
  output logic        EUACK,
  output logic [31:0] EDA,
  output logic [31:0] EDD_O,
  input  logic [31:0] EDD_I,
  output logic [1:0]  EDBC,
  output logic [3:0]  EDBE,
  output logic        EDWR,
  output logic        EDREQ,
  input  logic        EDACK,
  output logic [1:0]  OWNER
);
  arb_own_t own, sel;
  logic [CNT_W-1:0] starve_cnt;
  logic if_drop, if_ok, starved;
  bus_req_t eu_r, if_r, ed_r;
  always_comb begin
    if_ok = IFREQ & ~IFFLUSH;
    starved = starve_cnt == CNT_W'(STARVE_MAX);
    sel = own != ARB_IDLE ? own :
          (EUREQ & if_ok & starved) ? ARB_IF :
          EUREQ ? ARB_EU :
          if_ok ? ARB_IF : ARB_IDLE;
    eu_r = '{a: EUA, d: EUD_O, bc: EUBC, be: EUBE, wr: EUWR};
    if_r = '{a: {IFA, 2'b00}, d: 32'd0, bc: 2'd3, be: 4'hF, wr: 1'b0};
    ed_r = sel == ARB_IF ? if_r : eu_r;
  end
  assign {EDA, EDD_O, EDBC, EDBE, EDWR} = ed_r;
  assign EDREQ = ~RES & (sel != ARB_IDLE);
  assign EUACK = ~RES & EDACK & (sel == ARB_EU);
  assign IFACK = ~RES & EDACK & (sel == ARB_IF) & ~if_drop & ~IFFLUSH;
  assign IFD = EDD_I;
  assign EUD_I = EDD_I;
  assign OWNER = own;
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      own <= ARB_IDLE;
      starve_cnt <= '0;
      if_drop <= 1'b0;
    end else if (CE) begin
      own <= EDACK ? ARB_IDLE : sel;
      if_drop <= (sel == ARB_IF & EDACK) ? 1'b0 : (sel == ARB_IF & IFFLUSH) ? 1'b1 : if_drop;
      // dropping IFREQ wins over any completion in the same cycle
      starve_cnt <= ~IFREQ ? '0 :
                    (EDACK & sel == ARB_IF) ? '0 :
                    (EDACK & sel == ARB_EU & ~starved) ? starve_cnt + CNT_W'(1) : starve_cnt;
    end
  end
endmodule
